// File: rtl/spi_pkg.sv
// Shared types, widths and edge helper for the SPI responder.
package spi_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_dev_state_t;

  localparam int SpiByteW   = 8;
  localparam int SpiBitCntW = 3;

  // True when the synchronised line moves away from the idle level `cpol`.
  function automatic logic spi_is_leading(input logic cpol, input logic prev, input logic cur);
    return (prev == cpol) && (cur != cpol);
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for a single asynchronous input, reset to a chosen idle level.
module prim_flop_2sync #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_spi,
  input  logic rst_ni,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_spi or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= ResetValue;
      r_sync <= ResetValue;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_device_rx_fifo.sv
// First-word fall-through RX FIFO; the writer only pushes when not full or popping the same cycle.
module spi_device_rx_fifo
  import spi_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                clk_spi,
  input  logic                rst_ni,
  input  logic                i_push,
  input  logic [SpiByteW-1:0] i_data,
  input  logic                i_pop,
  output logic                o_full,
  output logic                o_empty,
  output logic [SpiByteW-1:0] o_data
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [SpiByteW-1:0] r_mem [Depth];
  logic [PtrW:0]       r_wptr;
  logic [PtrW:0]       r_rptr;

  always_ff @(posedge clk_spi or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push)             r_wptr <= r_wptr + PtrOne;
      if (i_pop && !o_empty)  r_rptr <= r_rptr + PtrOne;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are meaningful.
  always_ff @(posedge clk_spi) begin
    if (i_push) r_mem[r_wptr[PtrW-1:0]] <= i_data;
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                   (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr[PtrW-1:0]];

endmodule

// File: rtl/spi_device.sv
// SPI responder oversampled on clk_spi, byte-oriented, MSB first, full duplex.
// Define SPI_DEVICE_RX_FIFO_EN to replace the single RX holding register with a FIFO_DEPTH FIFO.
module spi_device
  import spi_pkg::*;
#(
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter int   FIFO_DEPTH = 4
) (
  input  logic                clk_spi,
  input  logic                rst_ni,
  input  logic                sck_i,
  input  logic                cs_ni,
  input  logic                sdi_i,
  output logic                sdo_o,
  output logic                sdo_en_o,
  input  logic [SpiByteW-1:0] tx_byte_i,
  output logic                tx_load_o,
  output logic [SpiByteW-1:0] rx_byte_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                overrun_o
);

  logic w_sck_sync, w_cs_sync, w_sdi_sync;

  prim_flop_2sync #(.ResetValue(CPOL)) u_sync_sck (
    .clk_spi(clk_spi), .rst_ni(rst_ni), .i_d(sck_i), .o_q(w_sck_sync));
  prim_flop_2sync #(.ResetValue(1'b1)) u_sync_cs (
    .clk_spi(clk_spi), .rst_ni(rst_ni), .i_d(cs_ni), .o_q(w_cs_sync));
  prim_flop_2sync #(.ResetValue(1'b0)) u_sync_sdi (
    .clk_spi(clk_spi), .rst_ni(rst_ni), .i_d(sdi_i), .o_q(w_sdi_sync));

  logic                  r_sck_prev, r_cs_prev;
  logic [1:0]            r_warm;
  logic                  r_cs_armed;
  spi_dev_state_t        r_state;
  logic [SpiBitCntW-1:0] r_bit_cnt;
  logic [SpiByteW-1:0]   r_tx_sh, r_rx_sh;
  logic                  r_new_byte;
  logic                  r_sdo, r_sdo_en, r_tx_load, r_overrun;

  // A select already in progress at reset release must not be mistaken for a new one:
  // only a falling cs_n seen after a genuinely high, fully synchronised cs_n is accepted.
  always_ff @(posedge clk_spi or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sck_prev <= CPOL;
      r_cs_prev  <= 1'b1;
      r_warm     <= 2'b00;
      r_cs_armed <= 1'b0;
    end else begin
      r_sck_prev <= w_sck_sync;
      r_cs_prev  <= w_cs_sync;
      r_warm     <= {r_warm[0], 1'b1};
      r_cs_armed <= r_cs_armed | (r_warm[1] & w_cs_sync);
    end
  end

  logic w_sck_lead, w_sck_trail, w_sample, w_shift, w_cs_fall, w_cs_rise;
  assign w_sck_lead  = spi_is_leading(CPOL, r_sck_prev, w_sck_sync);
  assign w_sck_trail = spi_is_leading(~CPOL, r_sck_prev, w_sck_sync);
  assign w_sample    = CPHA ? w_sck_trail : w_sck_lead;
  assign w_shift     = CPHA ? w_sck_lead  : w_sck_trail;
  assign w_cs_fall   = r_cs_armed & r_cs_prev & ~w_cs_sync;
  assign w_cs_rise   = ~r_cs_prev & w_cs_sync;

  logic                w_push, w_pop, w_full, w_accept, w_overrun;
  logic [SpiByteW-1:0] w_rx_next;
  assign w_push    = (r_state == ACTIVE) & ~w_cs_rise & w_sample & (r_bit_cnt == '1);
  assign w_rx_next = {r_rx_sh[SpiByteW-2:0], w_sdi_sync};
  assign w_pop     = rx_valid_o & rx_ready_i;
  assign w_accept  = w_push & (~w_full | w_pop);
  assign w_overrun = w_push & w_full & ~w_pop;

  // Mode 0/2 keeps bit 7 pre-loaded on sdo, so shifts emit bit 6; right after a reload bit 7 goes out unshifted.
  logic w_shift_bit, w_do_shift;
  assign w_shift_bit = (!CPHA && !r_new_byte) ? r_tx_sh[SpiByteW-2] : r_tx_sh[SpiByteW-1];
  assign w_do_shift  = CPHA || !r_new_byte;

  always_ff @(posedge clk_spi or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_new_byte <= 1'b0;
      r_sdo      <= 1'b1;
      r_sdo_en   <= 1'b0;
      r_tx_load  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      r_overrun <= w_overrun;
      case (r_state)
        IDLE: begin
          r_sdo    <= 1'b1;
          r_sdo_en <= 1'b0;
          if (w_cs_fall) begin
            r_state    <= ACTIVE;
            r_sdo_en   <= 1'b1;
            r_tx_sh    <= tx_byte_i;
            r_tx_load  <= 1'b1;
            r_bit_cnt  <= '0;
            r_new_byte <= 1'b0;
            if (!CPHA) r_sdo <= tx_byte_i[SpiByteW-1];
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_sdo_en  <= 1'b0;
            r_sdo     <= 1'b1;
          end else if (w_sample) begin
            r_rx_sh   <= w_rx_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == '1) begin
              r_tx_sh    <= tx_byte_i;
              r_tx_load  <= 1'b1;
              r_new_byte <= 1'b1;
            end
          end else if (w_shift) begin
            r_sdo      <= w_shift_bit;
            r_new_byte <= 1'b0;
            if (w_do_shift) r_tx_sh <= {r_tx_sh[SpiByteW-2:0], 1'b0};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sdo_o     = r_sdo;
  assign sdo_en_o  = r_sdo_en;
  assign tx_load_o = r_tx_load;
  assign overrun_o = r_overrun;

  logic w_unused;

`ifdef SPI_DEVICE_RX_FIFO_EN
  logic w_empty;

  spi_device_rx_fifo #(.Depth(FIFO_DEPTH)) u_rx_fifo (
    .clk_spi(clk_spi),
    .rst_ni (rst_ni),
    .i_push (w_accept),
    .i_data (w_rx_next),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_data (rx_byte_o)
  );

  assign rx_valid_o = ~w_empty;
  assign w_unused   = r_rx_sh[SpiByteW-1];
`else
  logic [SpiByteW-1:0] r_rx_byte;
  logic                r_rx_valid;

  always_ff @(posedge clk_spi or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_accept) begin
      r_rx_byte  <= w_rx_next;
      r_rx_valid <= 1'b1;
    end else if (w_pop) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign w_full     = r_rx_valid;
  assign rx_valid_o = r_rx_valid;
  assign rx_byte_o  = r_rx_byte;
  assign w_unused   = ^{r_rx_sh[SpiByteW-1], FIFO_DEPTH};
`endif

endmodule

// File: tb/tb_spi_device.sv
// Bench: one responder per SPI mode, driven in turn by a behavioural host; RX capacity model per build.
module tb_spi_device;

  localparam int FifoDepth = 4;
`ifdef SPI_DEVICE_RX_FIFO_EN
  localparam int Cap = FifoDepth;
`else
  localparam int Cap = 1;
`endif

  logic clk_spi = 1'b0;
  logic rst_ni  = 1'b0;

  logic       sck [4], cs_n [4], sdi [4], sdo [4], sdo_en [4];
  logic       tx_load [4], rx_valid [4], rx_ready [4], overrun [4];
  logic [7:0] tx_byte [4], rx_byte [4];

  int         tests_run = 0, tests_failed = 0;
  int         cur_m = 0;
  int         load_cnt = 0, ovr_cnt = 0;
  logic [7:0] got [$];
  logic [7:0] mosi_a [8], tx_a [8];

  always #10 clk_spi = ~clk_spi;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_device #(.CPOL(g >= 2), .CPHA(g % 2 == 1), .FIFO_DEPTH(FifoDepth)) u_dut (
      .clk_spi   (clk_spi),
      .rst_ni    (rst_ni),
      .sck_i     (sck[g]),
      .cs_ni     (cs_n[g]),
      .sdi_i     (sdi[g]),
      .sdo_o     (sdo[g]),
      .sdo_en_o  (sdo_en[g]),
      .tx_byte_i (tx_byte[g]),
      .tx_load_o (tx_load[g]),
      .rx_byte_o (rx_byte[g]),
      .rx_valid_o(rx_valid[g]),
      .rx_ready_i(rx_ready[g]),
      .overrun_o (overrun[g])
    );
  end

  // Consumer side of the mode under test: record every accepted byte and count pulses.
  always @(negedge clk_spi) begin
    if (rst_ni) begin
      if (rx_valid[cur_m] && rx_ready[cur_m]) got.push_back(rx_byte[cur_m]);
      if (tx_load[cur_m]) load_cnt++;
      if (overrun[cur_m]) ovr_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Half an SCK period (5 clk_spi cycles); all host actions land 2 ns after a clk_spi edge.
  task automatic half();
    repeat (5) @(posedge clk_spi);
    #2;
  endtask

  // Optionally raise rx_ready one cycle before the DUT acts on this sample edge.
  task automatic wait_after(input bit arm);
    if (arm) begin
      repeat (2) @(posedge clk_spi);
      #2;
      rx_ready[cur_m] = 1'b1;
      repeat (3) @(posedge clk_spi);
      #2;
    end else begin
      half();
    end
  endtask

  task automatic cs_low();
    cs_n[cur_m] = 1'b0;
    half();
    half();
  endtask

  task automatic cs_high();
    half();
    cs_n[cur_m] = 1'b1;
    half();
    half();
  endtask

  task automatic xfer(input logic [7:0] mosi, input int nbits, input bit arm, output logic [7:0] miso);
    logic cpol, cpha;
    cpol = (cur_m >= 2);
    cpha = (cur_m % 2 == 1);
    miso = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        sdi[cur_m] = mosi[i];
        half();
        sck[cur_m] = ~cpol;
        miso[i] = sdo[cur_m];
        wait_after(arm && i == 0);
        sck[cur_m] = cpol;
      end else begin
        sck[cur_m] = ~cpol;
        sdi[cur_m] = mosi[i];
        half();
        sck[cur_m] = cpol;
        miso[i] = sdo[cur_m];
        wait_after(arm && i == 0);
      end
    end
  endtask

  task automatic burst(input int n, input bit arm_last);
    logic [7:0] miso;
    tx_byte[cur_m] = tx_a[0];
    cs_low();
    for (int k = 0; k < n; k++) begin
      if (k + 1 < n) tx_byte[cur_m] = tx_a[k+1];
      xfer(mosi_a[k], 8, arm_last && (k == n - 1), miso);
      check($sformatf("m%0d miso[%0d]", cur_m, k), miso, tx_a[k]);
    end
    cs_high();
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      mosi_a[k] = 8'($urandom);
      tx_a[k]   = 8'($urandom);
    end
  endtask

  // Bytes delivered since index gb must be exactly mosi_a[0 .. n-1].
  task automatic check_rx(input string tag, input int gb, input int n);
    check($sformatf("m%0d %s rx_count", cur_m, tag), got.size() - gb, n);
    for (int k = 0; k < n; k++) begin
      if (gb + k < got.size())
        check($sformatf("m%0d %s rx[%0d]", cur_m, tag, k), got[gb+k], mosi_a[k]);
    end
  endtask

  task automatic check_reset_outputs(input int m, input string tag);
    check($sformatf("m%0d %s sdo", m, tag), sdo[m], 1'b1);
    check($sformatf("m%0d %s sdo_en", m, tag), sdo_en[m], 1'b0);
    check($sformatf("m%0d %s tx_load", m, tag), tx_load[m], 1'b0);
    check($sformatf("m%0d %s rx_valid", m, tag), rx_valid[m], 1'b0);
    check($sformatf("m%0d %s rx_byte", m, tag), rx_byte[m], 8'h00);
    check($sformatf("m%0d %s overrun", m, tag), overrun[m], 1'b0);
  endtask

  initial begin
    int gb, lb, ob, n_stored;
    logic [7:0] miso;

    for (int i = 0; i < 4; i++) begin
      sck[i]      = (i >= 2);
      cs_n[i]     = 1'b1;
      sdi[i]      = 1'b0;
      tx_byte[i]  = 8'h00;
      rx_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk_spi);
    #2;
    for (int i = 0; i < 4; i++) check_reset_outputs(i, "reset");
    rst_ni = 1'b1;
    half();
    half();

    for (int m = 0; m < 4; m++) begin
      cur_m = m;

      // Single byte: 0xA5 in, 0x3C out, one load at select and one after the byte.
      gb = got.size(); lb = load_cnt;
      tx_byte[m] = 8'h3C;
      cs_low();
      check($sformatf("m%0d sdo_en selected", m), sdo_en[m], 1'b1);
      xfer(8'hA5, 8, 1'b0, miso);
      check($sformatf("m%0d miso single", m), miso, 8'h3C);
      cs_high();
      mosi_a[0] = 8'hA5;
      check_rx("single", gb, 1);
      check($sformatf("m%0d tx_load count", m), load_cnt - lb, 2);
      check($sformatf("m%0d sdo_en deselected", m), sdo_en[m], 1'b0);

      // Back-to-back fixed pattern under one select.
      gb = got.size(); ob = ovr_cnt; lb = load_cnt;
      mosi_a[0] = 8'h01; mosi_a[1] = 8'h80; mosi_a[2] = 8'hFF;
      tx_a[0]   = 8'h11; tx_a[1]   = 8'h22; tx_a[2]   = 8'h33;
      burst(3, 1'b0);
      check_rx("b2b", gb, 3);
      check($sformatf("m%0d b2b overrun", m), ovr_cnt - ob, 0);
      check($sformatf("m%0d b2b tx_load count", m), load_cnt - lb, 4);

      // Random back-to-back burst.
      gb = got.size(); ob = ovr_cnt;
      fill_random(4);
      burst(4, 1'b0);
      check_rx("rand", gb, 4);
      check($sformatf("m%0d rand overrun", m), ovr_cnt - ob, 0);

      // Consumer stalled: capacity bytes kept, the rest dropped with one overrun each.
      gb = got.size(); ob = ovr_cnt;
      rx_ready[m] = 1'b0;
      fill_random(Cap + 1);
      burst(Cap + 1, 1'b0);
      n_stored = (Cap + 1 < Cap) ? Cap + 1 : Cap;
      check($sformatf("m%0d stall overrun", m), ovr_cnt - ob, (Cap + 1) - n_stored);
      check($sformatf("m%0d stall valid", m), rx_valid[m], 1'b1);
      check($sformatf("m%0d stall head", m), rx_byte[m], mosi_a[0]);
      rx_ready[m] = 1'b1;
      half();
      half();
      check_rx("stall", gb, n_stored);

      // Full storage with a pop in the push cycle: no overrun, new byte delivered last.
      gb = got.size(); ob = ovr_cnt;
      rx_ready[m] = 1'b0;
      fill_random(Cap + 1);
      burst(Cap + 1, 1'b1);
      half();
      half();
      check($sformatf("m%0d fullpop overrun", m), ovr_cnt - ob, 0);
      check_rx("fullpop", gb, Cap + 1);

      // Abort after 5 bits of 0x5A, then a clean 0xC3.
      gb = got.size(); ob = ovr_cnt;
      tx_byte[m] = 8'($urandom);
      cs_low();
      xfer(8'h5A, 5, 1'b0, miso);
      cs_n[m] = 1'b1;
      repeat (4) @(posedge clk_spi);
      #2;
      check($sformatf("m%0d abort sdo_en", m), sdo_en[m], 1'b0);
      half();
      half();
      check($sformatf("m%0d abort no push", m), got.size() - gb, 0);
      check($sformatf("m%0d abort overrun", m), ovr_cnt - ob, 0);
      mosi_a[0] = 8'hC3;
      tx_a[0]   = 8'($urandom);
      burst(1, 1'b0);
      check_rx("abort", gb, 1);

      // Reset mid-byte; the rest of that select must be ignored, then 0x96 arrives intact.
      gb = got.size();
      tx_byte[m] = 8'($urandom);
      cs_low();
      xfer(8'($urandom), 4, 1'b0, miso);
      rst_ni = 1'b0;
      half();
      check_reset_outputs(m, "midreset");
      rst_ni = 1'b1;
      xfer(8'($urandom), 8, 1'b0, miso);
      cs_high();
      mosi_a[0] = 8'h96;
      tx_a[0]   = 8'($urandom);
      burst(1, 1'b0);
      check_rx("reset", gb, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
